hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard and stall controller that drives the change-enable (`ce`) and bubble/flush controls consumed by the per-stage pipeline control registers (p1/p2 fetch/decode registers, p3 and later control registers). It detects load-use hazards between the decode stage and stage 3, squashes wrong-path instructions after a taken branch resolved in stage 3, and freezes the whole pipeline while external memory is busy. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- `REG_AW`, 3: register-address width.
- `LOAD_USE_CYCLES`, 1: total bubble cycles per load-use hazard (≥1).
- `FLUSH_CYCLES`, 2: total flush cycles per taken branch (≥1).
- `CNT_W`, 16: width of `stall_cycles`.

Ports:
- `clock` in 1: the block's single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `id_rs` in REG_AW: source register A of the instruction in decode.
- `id_rt` in REG_AW: source register B of the instruction in decode.
- `id_rs_use` in 1: decode instruction reads `id_rs`.
- `id_rt_use` in 1: decode instruction reads `id_rt`.
- `p3_memRead` in 1: stage-3 instruction is a load.
- `p3_regWren` in 1: stage-3 instruction writes a register.
- `p3_rd` in REG_AW: destination register of the stage-3 instruction.
- `branch_taken` in 1: taken branch resolved in stage 3 this cycle.
- `mem_busy` in 1: memory not ready; the pipeline must hold.
- `ce_fetch` out 1: enable for PC and the p1/p2 registers.
- `ce_pipe` out 1: `ce` for the stage-3-and-later control registers.
- `bubble` out 1: forces a nop (all-zero controls, opcode 0000) into the stage-3 register.
- `flush` out 1: clears p1/p2 to nop on the next enabled edge.
- `state` out 2: FSM state, for debug.
- `stall_cycles` out CNT_W: saturating count of cycles with `ce_fetch`=0.

## Operation
- `hazard` = `p3_memRead` & `p3_regWren` & (`p3_rd`≠0) & ((`id_rs_use` & `id_rs`==`p3_rd`) | (`id_rt_use` & `id_rt`==`p3_rd`)).
  - Register 0 never causes a hazard.
- FSM states:
  - RUN=0
  - LOADUSE=1
  - FLUSH=2
  - encoding 3 is unused and recovers to RUN on the next edge.
- Down-counter `cnt` is internal and `ceil(log2(max(LOAD_USE_CYCLES,FLUSH_CYCLES)+1))` bits wide.
- Outputs are combinational from state, `cnt` and inputs. Priority is `mem_busy` > `branch_taken` > `hazard` > normal.
- `mem_busy`=1, any state:
  - `ce_fetch`=`ce_pipe`=`bubble`=`flush`=0.
  - `state` and `cnt` hold.
  - No event is consumed; `branch_taken` and `hazard` are re-evaluated when `mem_busy` drops.
- `branch_taken`=1, any state:
  - Outputs: `ce_fetch`=1, `ce_pipe`=1, `flush`=1, `bubble`=1.
  - If FLUSH_CYCLES>1: next state FLUSH, `cnt`←FLUSH_CYCLES−1.
  - Otherwise: next state RUN.
  - A branch during FLUSH or LOADUSE restarts the flush.
- RUN with `hazard`:
  - Outputs: `ce_fetch`=0, `ce_pipe`=1, `bubble`=1, `flush`=0.
  - If LOAD_USE_CYCLES>1: next state LOADUSE, `cnt`←LOAD_USE_CYCLES−1.
- RUN, no event: `ce_fetch`=`ce_pipe`=1, `bubble`=`flush`=0.
- LOADUSE, no branch:
  - Outputs as in the hazard case.
  - `cnt` decrements; when `cnt`==1, next state RUN.
- FLUSH, no branch:
  - Outputs as in the branch case.
  - `cnt` decrements; when `cnt`==1, next state RUN.
- `stall_cycles`:
  - +1 on each edge where `ce_fetch`=0 and `reset`=0.
  - Saturates at 2^CNT_W−1.

## Timing
- `reset` high, asynchronously and for its whole duration:
  - `state`=RUN, `cnt`=0, `stall_cycles`=0.
  - `ce_fetch`=`ce_pipe`=`bubble`=`flush`=0.
- First normal decode happens in the cycle after `reset` falls.
- Zero-cycle latency: a hazard or branch affects outputs in the same cycle it is presented.
- Load-use: exactly LOAD_USE_CYCLES consecutive unfrozen cycles with `bubble`=1 and `ce_fetch`=0.
- Branch: exactly FLUSH_CYCLES consecutive unfrozen cycles with `flush`=1.
- `mem_busy` cycles are inserted without shortening either window.
- Reset asserted mid-LOADUSE or mid-FLUSH aborts immediately. There is no residual bubble after release.

## Test plan
- Reset release, no events: `ce_fetch`=`ce_pipe`=1, `bubble`=`flush`=0, `state`=0, `stall_cycles`=0 for 10 cycles.
- Load-use, LOAD_USE_CYCLES=1: `p3_memRead`=`p3_regWren`=1, `p3_rd`=3, `id_rs`=3, `id_rs_use`=1 for one cycle → that cycle `ce_fetch`=0, `bubble`=1; the next cycle is normal; `stall_cycles`=1. The same stimulus with `p3_rd`=0 → no stall.
- Branch, FLUSH_CYCLES=2: `branch_taken` pulsed for 1 cycle → `flush`=1 for 2 cycles, `state` goes 0→2→0, `ce_fetch`=1 throughout.
- Simultaneous `branch_taken` and `hazard` → branch wins: `flush`=1, `ce_fetch`=1, `state`=2.
- `mem_busy` held for 3 cycles in the middle of FLUSH → all enables 0 and `state`/`cnt` frozen during those 3 cycles; flush resumes and totals 2 flush cycles; `stall_cycles`=3.
- With CNT_W=2, hold `mem_busy` for 6 cycles → `stall_cycles` saturates at 3. Assert `reset` asynchronously mid-cycle → all outputs 0 immediately; `stall_cycles`=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Decode/stage-3 hazard inputs and pipeline enable/squash outputs of the stall controller.
// master drives the pipeline-side inputs, slave is the controller.
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_use;
  logic              id_rt_use;
  logic              p3_memRead;
  logic              p3_regWren;
  logic [REG_AW-1:0] p3_rd;
  logic              branch_taken;
  logic              mem_busy;
  logic              ce_fetch;
  logic              ce_pipe;
  logic              bubble;
  logic              flush;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_rs, id_rt, id_rs_use, id_rt_use, p3_memRead, p3_regWren, p3_rd,
           branch_taken, mem_busy,
    input  ce_fetch, ce_pipe, bubble, flush, state, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_rs_use, id_rt_use, p3_memRead, p3_regWren, p3_rd,
           branch_taken, mem_busy,
    output ce_fetch, ce_pipe, bubble, flush, state, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / taken-branch / memory-wait pipeline stall controller with a
// saturating stall-cycle counter.
//
// state   | meaning
// RUN     | normal issue, hazards evaluated each cycle
// LOADUSE | remaining load-use bubble cycles, fetch held
// FLUSH   | remaining wrong-path squash cycles after a taken branch
// (3)     | unused, returns to RUN
module hazard_stall_ctrl #(
  parameter int REG_AW          = 3,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 2,
  parameter int CNT_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  hazard_stall_ctrl_if.slave bus
);
  localparam int MAX_CYC = (LOAD_USE_CYCLES > FLUSH_CYCLES) ? LOAD_USE_CYCLES : FLUSH_CYCLES;
  localparam int CW      = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

  localparam logic [CW-1:0]     LU_RELOAD = CW'(LOAD_USE_CYCLES - 1);
  localparam logic [CW-1:0]     FL_RELOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [CNT_W-1:0]  STALL_MAX = '1;
  localparam logic [REG_AW-1:0] REG_ZERO  = '0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOADUSE = 2'd1,
    FLUSH   = 2'd2,
    UNUSED  = 2'd3
  } state_t;

  state_t           st;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] stalls;
  logic             hazard;
  logic             ce_fetch_c;
  logic             ce_pipe_c;
  logic             bubble_c;
  logic             flush_c;

  assign hazard = bus.p3_memRead & bus.p3_regWren & (bus.p3_rd != REG_ZERO) &
                  ((bus.id_rs_use & (bus.id_rs == bus.p3_rd)) |
                   (bus.id_rt_use & (bus.id_rt == bus.p3_rd)));

  // Reset gates the outputs directly so they drop the instant reset rises.
  always_comb begin
    ce_fetch_c = 1'b0;
    ce_pipe_c  = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    if (!reset && !bus.mem_busy) begin
      if (bus.branch_taken || st == FLUSH) begin
        ce_fetch_c = 1'b1;
        ce_pipe_c  = 1'b1;
        bubble_c   = 1'b1;
        flush_c    = 1'b1;
      end else if (st == LOADUSE || hazard) begin
        ce_pipe_c  = 1'b1;
        bubble_c   = 1'b1;
      end else begin
        ce_fetch_c = 1'b1;
        ce_pipe_c  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st     <= RUN;
      cnt    <= '0;
      stalls <= '0;
    end else begin
      if (!ce_fetch_c && stalls != STALL_MAX)
        stalls <= stalls + CNT_W'(1);
      // A busy memory freezes the window so no event is consumed.
      if (!bus.mem_busy) begin
        if (bus.branch_taken) begin
          if (FLUSH_CYCLES > 1) begin
            st  <= FLUSH;
            cnt <= FL_RELOAD;
          end else begin
            st  <= RUN;
            cnt <= '0;
          end
        end else begin
          case (st)
            RUN: begin
              if (hazard && LOAD_USE_CYCLES > 1) begin
                st  <= LOADUSE;
                cnt <= LU_RELOAD;
              end
            end
            LOADUSE, FLUSH: begin
              cnt <= cnt - CNT_ONE;
              if (cnt == CNT_ONE)
                st <= RUN;
            end
            default: begin
              st  <= RUN;
              cnt <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.ce_fetch     = ce_fetch_c;
  assign bus.ce_pipe      = ce_pipe_c;
  assign bus.bubble       = bubble_c;
  assign bus.flush        = flush_c;
  assign bus.state        = st;
  assign bus.stall_cycles = stalls;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (default and LU=3/FL=3/CNT_W=2)
// share directed and random stimulus, checked against a window-count model.
module tb_hazard_stall_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hazard_stall_ctrl_if #(.REG_AW(3), .CNT_W(16)) bus_a ();
  hazard_stall_ctrl_if #(.REG_AW(3), .CNT_W(2))  bus_b ();

  hazard_stall_ctrl #(.REG_AW(3), .LOAD_USE_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );
  hazard_stall_ctrl #(.REG_AW(3), .LOAD_USE_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining flush / load-use window lengths and total stall count.
  int lu_cyc[2]  = '{1, 3};
  int fl_cyc[2]  = '{2, 3};
  int sat[2]     = '{65535, 3};
  int lu_left[2] = '{0, 0};
  int fl_left[2] = '{0, 0};
  int stalls[2]  = '{0, 0};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_a();
    return {26'd0, bus_a.ce_fetch, bus_a.ce_pipe, bus_a.bubble, bus_a.flush, bus_a.state};
  endfunction

  function automatic logic [31:0] obs_b();
    return {26'd0, bus_b.ce_fetch, bus_b.ce_pipe, bus_b.bubble, bus_b.flush, bus_b.state};
  endfunction

  task automatic model_check(input int i, input string nm, input logic [31:0] obs,
                             input logic [31:0] obs_stall, input logic hz, input logic br,
                             input logic mb);
    logic [3:0] ctl;
    int st;
    int es;
    st = (fl_left[i] > 0) ? 2 : ((lu_left[i] > 0) ? 1 : 0);
    if (mb) ctl = 4'b0000;
    else if (br) begin
      ctl = 4'b1111;
      fl_left[i] = fl_cyc[i] - 1;
      lu_left[i] = 0;
    end else if (fl_left[i] > 0) begin
      ctl = 4'b1111;
      fl_left[i]--;
    end else if (lu_left[i] > 0) begin
      ctl = 4'b0110;
      lu_left[i]--;
    end else if (hz) begin
      ctl = 4'b0110;
      lu_left[i] = lu_cyc[i] - 1;
    end else ctl = 4'b1100;
    es = (stalls[i] < sat[i]) ? stalls[i] : sat[i];
    check_val($sformatf("%s_ctl_state", nm), obs, {26'd0, ctl, st[1:0]});
    check_val($sformatf("%s_stall", nm), obs_stall, es);
    if (!ctl[3]) stalls[i]++;
  endtask

  task automatic cycle(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic rsu, input logic rtu, input logic mr, input logic rw,
                       input logic br, input logic mb);
    logic hz;
    @(negedge clock);
    bus_a.id_rs = rs;  bus_b.id_rs = rs;
    bus_a.id_rt = rt;  bus_b.id_rt = rt;
    bus_a.p3_rd = rd;  bus_b.p3_rd = rd;
    bus_a.id_rs_use = rsu;  bus_b.id_rs_use = rsu;
    bus_a.id_rt_use = rtu;  bus_b.id_rt_use = rtu;
    bus_a.p3_memRead = mr;  bus_b.p3_memRead = mr;
    bus_a.p3_regWren = rw;  bus_b.p3_regWren = rw;
    bus_a.branch_taken = br; bus_b.branch_taken = br;
    bus_a.mem_busy = mb;    bus_b.mem_busy = mb;
    hz = mr & rw & (rd != 3'd0) & ((rsu & (rs == rd)) | (rtu & (rt == rd)));
    #1;
    model_check(0, "a", obs_a(), {16'd0, bus_a.stall_cycles}, hz, br, mb);
    model_check(1, "b", obs_b(), {30'd0, bus_b.stall_cycles}, hz, br, mb);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check_val($sformatf("%s_a_outs", nm), obs_a(), 32'd0);
    check_val($sformatf("%s_a_stall", nm), {16'd0, bus_a.stall_cycles}, 32'd0);
    check_val($sformatf("%s_b_outs", nm), obs_b(), 32'd0);
    check_val($sformatf("%s_b_stall", nm), {30'd0, bus_b.stall_cycles}, 32'd0);
  endtask

  // Reset rises mid-cycle and is released just after the next rising edge.
  task automatic reset_mid();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    for (int i = 0; i < 2; i++) begin
      lu_left[i] = 0;
      fl_left[i] = 0;
      stalls[i]  = 0;
    end
    @(posedge clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    bus_a.id_rs = '0; bus_a.id_rt = '0; bus_a.p3_rd = '0;
    bus_a.id_rs_use = 1'b0; bus_a.id_rt_use = 1'b0; bus_a.p3_memRead = 1'b0;
    bus_a.p3_regWren = 1'b0; bus_a.branch_taken = 1'b0; bus_a.mem_busy = 1'b0;
    bus_b.id_rs = '0; bus_b.id_rt = '0; bus_b.p3_rd = '0;
    bus_b.id_rs_use = 1'b0; bus_b.id_rt_use = 1'b0; bus_b.p3_memRead = 1'b0;
    bus_b.p3_regWren = 1'b0; bus_b.branch_taken = 1'b0; bus_b.mem_busy = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    idle(10);
    // load-use on rs, then the same with p3_rd = 0
    cycle(3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    cycle(3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    // load-use through rt only
    cycle(3'd1, 3'd5, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    // taken branch pulse
    cycle(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    // branch and hazard together
    cycle(3'd2, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    // memory wait in the middle of a flush
    cycle(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    // long memory wait saturates the narrow counter
    for (int k = 0; k < 6; k++) cycle(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // reset in the middle of a load-use window on the long instance
    cycle(3'd4, 3'd0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    reset_mid();
    idle(3);

    for (int n = 0; n < 600; n++) begin
      logic [2:0] rs, rt, rd;
      rd = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 1) == 0) ? rd : 3'($urandom_range(0, 7));
      rt = ($urandom_range(0, 2) == 0) ? rd : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) reset_mid();
      cycle(rs, rt, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 15));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
